// File: rtl/l2_req_arbiter.sv
// Round-robin arbiter sharing one L2 request port among NREQ channels, with a
// single outstanding transaction, response routing and a response watchdog.
module l2_req_arbiter #(
  parameter int NREQ      = 4,
  parameter int ADDR_BITS = 48,
  parameter int LINE_BITS = 256,
  parameter int TYPE_BITS = 4,
  parameter int TIMEOUT   = 1023
) (
  input  logic                           i_clk,
  input  logic                           i_nrst,
  input  logic [NREQ-1:0]                i_rq_valid,
  input  logic [NREQ*TYPE_BITS-1:0]      i_rq_type,
  input  logic [NREQ*ADDR_BITS-1:0]      i_rq_addr,
  input  logic [NREQ*3-1:0]              i_rq_size,
  input  logic [NREQ*3-1:0]              i_rq_prot,
  input  logic [NREQ*LINE_BITS-1:0]      i_rq_wdata,
  input  logic [NREQ*LINE_BITS/8-1:0]    i_rq_wstrb,
  output logic [NREQ-1:0]                o_rq_ready,
  output logic [NREQ-1:0]                o_rs_valid,
  output logic [LINE_BITS-1:0]           o_rs_rdata,
  output logic [1:0]                     o_rs_status,
  input  logic                           i_req_ready,
  output logic                           o_req_valid,
  output logic [TYPE_BITS-1:0]           o_req_type,
  output logic [ADDR_BITS-1:0]           o_req_addr,
  output logic [2:0]                     o_req_size,
  output logic [2:0]                     o_req_prot,
  output logic [LINE_BITS-1:0]           o_req_wdata,
  output logic [LINE_BITS/8-1:0]         o_req_wstrb,
  input  logic                           i_resp_valid,
  input  logic [LINE_BITS-1:0]           i_resp_rdata,
  input  logic [1:0]                     i_resp_status,
  output logic                           o_err_stray
);

  localparam int STRB_BITS = LINE_BITS / 8;
  localparam int SW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMAX = {TW{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_TOUT
  } state_e;

  state_e                 state_q, state_d;
  logic [SW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [SW-1:0]          srcid_q, srcid_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [TYPE_BITS-1:0]   type_q, type_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [2:0]             size_q, size_d;
  logic [2:0]             prot_q, prot_d;
  logic [LINE_BITS-1:0]   wdata_q, wdata_d;
  logic [STRB_BITS-1:0]   wstrb_q, wstrb_d;
  logic                   err_stray_q, err_stray_d;

  logic                   grant_found;
  logic [SW-1:0]          grant_idx;

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    int ch;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      ch = int'(rr_ptr_q) + i;
      if (ch >= NREQ) ch = ch - NREQ;
      if (!grant_found && i_rq_valid[ch]) begin
        grant_found = 1'b1;
        grant_idx   = SW'(ch);
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    srcid_d   = srcid_q;
    timer_d   = timer_q;
    type_d    = type_q;
    addr_d    = addr_q;
    size_d    = size_q;
    prot_d    = prot_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    err_stray_d = err_stray_q |
                  (i_resp_valid && (state_q == ST_IDLE || state_q == ST_REQ));

    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          type_d   = i_rq_type [int'(grant_idx)*TYPE_BITS +: TYPE_BITS];
          addr_d   = i_rq_addr [int'(grant_idx)*ADDR_BITS +: ADDR_BITS];
          size_d   = i_rq_size [int'(grant_idx)*3 +: 3];
          prot_d   = i_rq_prot [int'(grant_idx)*3 +: 3];
          wdata_d  = i_rq_wdata[int'(grant_idx)*LINE_BITS +: LINE_BITS];
          wstrb_d  = i_rq_wstrb[int'(grant_idx)*STRB_BITS +: STRB_BITS];
          srcid_d  = grant_idx;
          rr_ptr_d = (grant_idx == SW'(NREQ - 1)) ? '0 : SW'(grant_idx + 1'b1);
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_req_ready) begin
          state_d = ST_WAIT;
          timer_d = '0;
        end
      end
      ST_WAIT: begin
        if (i_resp_valid) begin
          state_d = ST_IDLE;
        end else begin
          if (timer_q != TMAX) timer_d = timer_q + 1'b1;
          if ((TIMEOUT != 0) && (timer_q == TW'(TIMEOUT - 1))) state_d = ST_TOUT;
        end
      end
      ST_TOUT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are forced low while reset is held, including the combinational grant.
  always_comb begin
    o_rq_ready  = '0;
    o_rs_valid  = '0;
    o_rs_rdata  = '0;
    o_rs_status = 2'b00;
    if (state_q == ST_IDLE && grant_found && i_nrst) o_rq_ready[grant_idx] = 1'b1;
    if (state_q == ST_WAIT) begin
      o_rs_valid[srcid_q] = i_resp_valid;
      o_rs_rdata          = i_resp_rdata;
      o_rs_status         = i_resp_status;
    end else if (state_q == ST_TOUT) begin
      o_rs_valid[srcid_q] = 1'b1;
      o_rs_status         = 2'b11;
    end
  end

  assign o_req_valid = (state_q == ST_REQ);
  assign o_req_type  = type_q;
  assign o_req_addr  = addr_q;
  assign o_req_size  = size_q;
  assign o_req_prot  = prot_q;
  assign o_req_wdata = wdata_q;
  assign o_req_wstrb = wstrb_q;
  assign o_err_stray = err_stray_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  // NOTE: the latched datapath is reset too, since the request outputs must read 0 out of reset.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      srcid_q     <= '0;
      timer_q     <= '0;
      type_q      <= '0;
      addr_q      <= '0;
      size_q      <= '0;
      prot_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      err_stray_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      srcid_q     <= srcid_d;
      timer_q     <= timer_d;
      type_q      <= type_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      prot_q      <= prot_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      err_stray_q <= err_stray_d;
    end
  end

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Self-checking bench for l2_req_arbiter: directed scenarios plus randomized
// traffic, all compared every cycle against a transaction-level reference model.
module tb_l2_req_arbiter;

  localparam int NREQ = 4;
  localparam int AB   = 48;
  localparam int LB   = 256;
  localparam int TB   = 4;
  localparam int SB   = LB / 8;
  localparam int TOUT = 16;

  logic                 clk = 1'b0;
  logic                 nrst;
  logic [NREQ-1:0]      rq_valid;
  logic [NREQ*TB-1:0]   rq_type;
  logic [NREQ*AB-1:0]   rq_addr;
  logic [NREQ*3-1:0]    rq_size;
  logic [NREQ*3-1:0]    rq_prot;
  logic [NREQ*LB-1:0]   rq_wdata;
  logic [NREQ*SB-1:0]   rq_wstrb;
  logic [NREQ-1:0]      o_rq_ready;
  logic [NREQ-1:0]      o_rs_valid;
  logic [LB-1:0]        o_rs_rdata;
  logic [1:0]           o_rs_status;
  logic                 req_ready;
  logic                 o_req_valid;
  logic [TB-1:0]        o_req_type;
  logic [AB-1:0]        o_req_addr;
  logic [2:0]           o_req_size;
  logic [2:0]           o_req_prot;
  logic [LB-1:0]        o_req_wdata;
  logic [SB-1:0]        o_req_wstrb;
  logic                 resp_valid;
  logic [LB-1:0]        resp_rdata;
  logic [1:0]           resp_status;
  logic                 o_err_stray;

  l2_req_arbiter #(
    .NREQ(NREQ), .ADDR_BITS(AB), .LINE_BITS(LB), .TYPE_BITS(TB), .TIMEOUT(TOUT)
  ) dut (
    .i_clk(clk), .i_nrst(nrst),
    .i_rq_valid(rq_valid), .i_rq_type(rq_type), .i_rq_addr(rq_addr),
    .i_rq_size(rq_size), .i_rq_prot(rq_prot), .i_rq_wdata(rq_wdata),
    .i_rq_wstrb(rq_wstrb),
    .o_rq_ready(o_rq_ready), .o_rs_valid(o_rs_valid), .o_rs_rdata(o_rs_rdata),
    .o_rs_status(o_rs_status),
    .i_req_ready(req_ready), .o_req_valid(o_req_valid), .o_req_type(o_req_type),
    .o_req_addr(o_req_addr), .o_req_size(o_req_size), .o_req_prot(o_req_prot),
    .o_req_wdata(o_req_wdata), .o_req_wstrb(o_req_wstrb),
    .i_resp_valid(resp_valid), .i_resp_rdata(resp_rdata),
    .i_resp_status(resp_status), .o_err_stray(o_err_stray)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one transaction in flight, described by whether it is
  // waiting for the L2 to accept it, how long it has waited for a response,
  // and whether a timeout report is due.
  bit          m_busy, m_acc, m_tout, m_stray;
  int          m_owner, m_ptr, m_waited;
  logic [TB-1:0] m_type;
  logic [AB-1:0] m_addr;
  logic [2:0]    m_size, m_prot;
  logic [LB-1:0] m_wdata;
  logic [SB-1:0] m_wstrb;
  int          grants_q[$];

  task automatic model_reset();
    m_busy = 0; m_acc = 0; m_tout = 0; m_stray = 0;
    m_owner = 0; m_ptr = 0; m_waited = 0;
    m_type = '0; m_addr = '0; m_size = '0; m_prot = '0; m_wdata = '0; m_wstrb = '0;
  endtask

  function automatic int pick();
    int c;
    for (int i = 0; i < NREQ; i++) begin
      c = (m_ptr + i) % NREQ;
      if (rq_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic randomize_fields();
    for (int k = 0; k < NREQ; k++) begin
      rq_type[k*TB +: TB] = TB'($urandom);
      rq_addr[k*AB +: AB] = AB'({$urandom, $urandom});
      rq_size[k*3 +: 3]   = 3'($urandom);
      rq_prot[k*3 +: 3]   = 3'($urandom);
      rq_wstrb[k*SB +: SB] = SB'($urandom);
      for (int w = 0; w < LB / 32; w++) rq_wdata[k*LB + w*32 +: 32] = $urandom;
    end
    for (int w = 0; w < LB / 32; w++) resp_rdata[w*32 +: 32] = $urandom;
  endtask

  // Compare all outputs at mid-cycle against the model's prediction.
  task automatic sample_check();
    int g;
    logic [NREQ-1:0] e_ready, e_rsv;
    logic [1:0]      e_st;
    logic [LB-1:0]   e_rd;
    #4;
    g = (!m_busy && !m_tout) ? pick() : -1;
    e_ready = '0;
    if (g >= 0) e_ready[g] = 1'b1;
    e_rsv = '0; e_st = 2'b00; e_rd = '0;
    if (m_tout) begin
      e_rsv[m_owner] = 1'b1;
      e_st = 2'b11;
    end else if (m_busy && m_acc) begin
      e_rsv[m_owner] = resp_valid;
      e_st = resp_status;
      e_rd = resp_rdata;
    end
    check("rq_ready",  LB'(o_rq_ready),  LB'(e_ready));
    check("rs_valid",  LB'(o_rs_valid),  LB'(e_rsv));
    check("rs_status", LB'(o_rs_status), LB'(e_st));
    check("rs_rdata",  o_rs_rdata,       e_rd);
    check("req_valid", LB'(o_req_valid), LB'(m_busy && !m_acc));
    check("req_type",  LB'(o_req_type),  LB'(m_type));
    check("req_addr",  LB'(o_req_addr),  LB'(m_addr));
    check("req_size",  LB'(o_req_size),  LB'(m_size));
    check("req_prot",  LB'(o_req_prot),  LB'(m_prot));
    check("req_wdata", o_req_wdata,      m_wdata);
    check("req_wstrb", LB'(o_req_wstrb), LB'(m_wstrb));
    check("err_stray", LB'(o_err_stray), LB'(m_stray));
    for (int k = 0; k < NREQ; k++) if (o_rq_ready[k]) grants_q.push_back(k);
  endtask

  // Advance one clock and apply the arbitration rules to the model.
  task automatic tick();
    int g;
    @(posedge clk);
    if (m_tout) begin
      m_tout = 0;
    end else if (!m_busy) begin
      if (resp_valid) m_stray = 1;
      g = pick();
      if (g >= 0) begin
        m_busy = 1; m_acc = 0; m_owner = g; m_ptr = (g + 1) % NREQ;
        m_type  = rq_type[g*TB +: TB];
        m_addr  = rq_addr[g*AB +: AB];
        m_size  = rq_size[g*3 +: 3];
        m_prot  = rq_prot[g*3 +: 3];
        m_wdata = rq_wdata[g*LB +: LB];
        m_wstrb = rq_wstrb[g*SB +: SB];
      end
    end else if (!m_acc) begin
      if (resp_valid) m_stray = 1;
      if (req_ready) begin m_acc = 1; m_waited = 0; end
    end else if (resp_valid) begin
      m_busy = 0;
    end else begin
      m_waited++;
      if (TOUT != 0 && m_waited == TOUT) begin m_busy = 0; m_tout = 1; end
    end
    #1;
  endtask

  // Drive the in-flight transaction to completion with an immediate response.
  task automatic complete();
    for (int i = 0; i < 50; i++) begin
      req_ready  = 1'b1;
      resp_valid = m_busy && m_acc;
      resp_status = 2'b00;
      sample_check();
      tick();
      resp_valid = 1'b0;
      if (!m_busy && !m_tout) return;
    end
    check("complete_bound", 1, 0);
  endtask

  logic [AB-1:0] saved_addr;
  int n;

  initial begin
    nrst = 1'b0; rq_valid = '0; rq_type = '0; rq_addr = '0; rq_size = '0;
    rq_prot = '0; rq_wdata = '0; rq_wstrb = '0; req_ready = 1'b0;
    resp_valid = 1'b0; resp_rdata = '0; resp_status = 2'b00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", LB'(o_req_valid), 0);
    check("rst_rs_valid",  LB'(o_rs_valid),  0);
    check("rst_err_stray", LB'(o_err_stray), 0);
    nrst = 1'b1;

    // Single request on channel 2.
    randomize_fields();
    rq_valid = 4'b0100;
    rq_addr[2*AB +: AB] = 48'h0000_8000_0040;
    rq_type[2*TB +: TB] = 4'b0010;
    req_ready = 1'b1;
    sample_check();
    check("single_ready", LB'(o_rq_ready), LB'(4'b0100));
    tick();
    rq_valid = '0;
    sample_check();
    check("single_req_valid", LB'(o_req_valid), 1);
    check("single_req_addr",  LB'(o_req_addr), LB'(48'h0000_8000_0040));
    check("single_req_type",  LB'(o_req_type), LB'(4'b0010));
    tick();
    resp_valid = 1'b1; resp_status = 2'b00; resp_rdata = {(LB/8){8'hA5}};
    sample_check();
    check("single_rs_valid", LB'(o_rs_valid), LB'(4'b0100));
    check("single_rs_rdata", o_rs_rdata, {(LB/8){8'hA5}});
    tick();
    resp_valid = 1'b0;

    // Pointer must now sit at channel 3.
    rq_valid = 4'b1111;
    sample_check();
    check("rr_ptr_after_ch2", LB'(o_rq_ready), LB'(4'b1000));
    tick();
    rq_valid = '0;
    complete();

    // Fairness: all channels valid for 8 grants.
    grants_q.delete();
    rq_valid = 4'b1111;
    for (int i = 0; i < 200 && grants_q.size() < 8; i++) begin
      req_ready = 1'b1;
      resp_valid = m_busy && m_acc;
      sample_check();
      tick();
      resp_valid = 1'b0;
    end
    rq_valid = '0;
    check("fair_count", LB'(grants_q.size()), 8);
    for (int i = 0; i < 8 && i < grants_q.size(); i++)
      check($sformatf("fair_grant%0d", i), LB'(grants_q[i]), LB'(i % NREQ));
    complete();

    // Backpressure: L2 stalls for 5 cycles while inputs churn.
    rq_valid = 4'b0010; req_ready = 1'b0;
    sample_check();
    check("bp_grant", LB'(o_rq_ready), LB'(4'b0010));
    saved_addr = rq_addr[1*AB +: AB];
    tick();
    rq_valid = '0;
    for (int i = 0; i < 5; i++) begin
      randomize_fields();
      sample_check();
      check("bp_hold_valid", LB'(o_req_valid), 1);
      check("bp_hold_addr",  LB'(o_req_addr), LB'(saved_addr));
      tick();
    end
    req_ready = 1'b1;
    sample_check();
    tick();
    sample_check();
    check("bp_wait_entered", LB'(o_req_valid), 0);
    tick();
    complete();

    // Timeout: request accepted, no response.
    rq_valid = 4'b0100;
    sample_check();
    tick();
    rq_valid = '0; req_ready = 1'b1;
    sample_check();
    tick();
    n = -1;
    for (int i = 0; i < 40; i++) begin
      sample_check();
      if (o_rs_valid != '0) begin
        n = i;
        check("tout_rs_valid", LB'(o_rs_valid), LB'(4'b0100));
        check("tout_status",   LB'(o_rs_status), LB'(2'b11));
      end
      tick();
      if (n >= 0) break;
    end
    check("tout_cycles", LB'(n), LB'(TOUT));
    repeat (2) begin sample_check(); tick(); end
    resp_valid = 1'b1; resp_status = 2'b01;
    sample_check();
    check("stray_not_fwd", LB'(o_rs_valid), 0);
    tick();
    resp_valid = 1'b0;
    sample_check();
    check("stray_flag", LB'(o_err_stray), 1);
    tick();

    // Error status on a write from channel 0.
    rq_valid = 4'b0001; rq_type[0 +: TB] = 4'b0001;
    sample_check();
    tick();
    rq_valid = '0;
    sample_check();
    check("err_req_type", LB'(o_req_type), LB'(4'b0001));
    tick();
    resp_valid = 1'b1; resp_status = 2'b10;
    sample_check();
    check("err_rs_valid", LB'(o_rs_valid), LB'(4'b0001));
    check("err_rs_status", LB'(o_rs_status), LB'(2'b10));
    tick();
    resp_valid = 1'b0; resp_status = 2'b00;

    // Reset in WaitResp after granting channel 2 (pointer would otherwise favour ch3).
    rq_valid = 4'b0100;
    sample_check();
    tick();
    sample_check();
    tick();
    sample_check();
    tick();
    #1 nrst = 1'b0;
    #1;
    check("mid_rst_rq_ready",  LB'(o_rq_ready),  0);
    check("mid_rst_rs_valid",  LB'(o_rs_valid),  0);
    check("mid_rst_rs_status", LB'(o_rs_status), 0);
    check("mid_rst_rs_rdata",  o_rs_rdata,       0);
    check("mid_rst_req_valid", LB'(o_req_valid), 0);
    check("mid_rst_req_addr",  LB'(o_req_addr),  0);
    check("mid_rst_req_wdata", o_req_wdata,      0);
    check("mid_rst_err_stray", LB'(o_err_stray), 0);
    model_reset();
    @(posedge clk);
    #1;
    rq_valid = 4'b1001;
    nrst = 1'b1;
    sample_check();
    check("rst_first_grant", LB'(o_rq_ready), LB'(4'b0001));
    tick();
    rq_valid = '0;
    complete();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      randomize_fields();
      rq_valid    = NREQ'($urandom);
      req_ready   = ($urandom_range(2) != 0);
      resp_valid  = ($urandom_range(19) == 0);
      resp_status = 2'($urandom);
      sample_check();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit reached");
  end

endmodule
